// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind a UART receiver: one push per rising edge of rx_done, first-word fall-through read.
// Define UART_RX_FIFO_OVF_FLAG_EN to enable the sticky overflow flag. Without it, overflow is tied to 0.
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         rx_data,
  input  logic                     rx_done,
  input  logic                     rd,
  output logic [WIDTH-1:0]         dout,
  output logic                     valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  input  logic                     ovf_clr,
  output logic                     overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             rx_done_q;
  logic             push_evt, push, pop, dropped;

  assign push_evt = rx_done & ~rx_done_q;
  assign valid    = (count != '0);
  assign full     = (count == FULL_CNT);
  assign pop      = rd & valid;
  // A pop in the same cycle frees a slot, so a push while full is still taken.
  assign push     = push_evt & (~full | pop);
  assign dropped  = push_evt & full & ~pop;
  assign dout     = valid ? mem[rd_ptr] : '0;

  // rx_done_q resets high so a level already asserted at release is not a push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_done_q <= 1'b1;
    else     rx_done_q <= rx_done;
  end

  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef UART_RX_FIFO_OVF_FLAG_EN
  // Set has priority over clear so a drop in the clear cycle is not lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          overflow <= 1'b0;
    else if (dropped) overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end
`else
  logic unused_ovf;
  assign unused_ovf = ovf_clr ^ dropped;
  assign overflow   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: the driver queues expected bytes, and the monitor checks every pop.
module tb_uart_rx_fifo;
  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
`ifdef UART_RX_FIFO_OVF_FLAG_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst, rx_done, rd, ovf_clr;
  logic [WIDTH-1:0] rx_data, dout;
  logic             valid, full, overflow;
  logic [$clog2(DEPTH):0] count;

  int n_cmp = 0;
  int n_bad = 0;
  logic [WIDTH-1:0] exp_q[$];

  uart_rx_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done), .rd(rd),
    .dout(dout), .valid(valid), .full(full), .count(count),
    .ovf_clr(ovf_clr), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every pop the DUT will take at the next edge must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && rd && valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL pop_unexpected: got %0h expected nothing", dout);
      end else begin
        chk("pop_data", 32'(dout), 32'(exp_q.pop_front()));
      end
    end
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic push(input logic [7:0] b, input bit acc);
    rx_data = b;
    rx_done = 1'b1;
    if (acc) exp_q.push_back(b);
    @(posedge clk); #1;
    rx_done = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic drain(input string name);
    bit done = 1'b0;
    rd = 1'b1;
    for (int i = 0; i < 3*DEPTH && !done; i++) begin
      @(posedge clk); #1;
      if (!valid) done = 1'b1;
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got valid=1 expected valid=0", name);
    end
    // rd held on an empty queue must be ignored.
    @(posedge clk); #1;
    rd = 1'b0;
    chk({name, "_count"}, 32'(count), 0);
    chk({name, "_dout"}, 32'(dout), 0);
    chk({name, "_sb_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rx_done = 1'b0; rd = 1'b0; ovf_clr = 1'b0; rx_data = '0;
    repeat (3) @(posedge clk); #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_dout", 32'(dout), 0);
    chk("rst_ovf", 32'(overflow), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // A long rx_done level gives exactly one push, visible the cycle after the edge.
    rx_data = 8'h5A; rx_done = 1'b1;
    chk("lat_pre_valid", 32'(valid), 0);
    @(posedge clk); #1;
    exp_q.push_back(8'h5A);
    chk("lat_valid", 32'(valid), 1);
    chk("lat_count", 32'(count), 1);
    chk("lat_dout", 32'(dout), 32'h5A);
    repeat (19) @(posedge clk); #1;
    chk("level_count", 32'(count), 1);
    rx_done = 1'b0;
    @(posedge clk); #1;
    rd = 1'b1;
    @(posedge clk); #1;
    rd = 1'b0;
    chk("pop1_count", 32'(count), 0);

    // Fill to full, then drain in order.
    for (int i = 1; i <= 8; i++) push(8'(i), 1'b1);
    chk("fill_full", 32'(full), 1);
    chk("fill_count", 32'(count), 8);
    drain("drain1");

    // Drop while full, overflow set and clear, set beats clear.
    for (int i = 1; i <= 8; i++) push(8'(i), 1'b1);
    push(8'h99, 1'b0);
    chk("drop_count", 32'(count), 8);
    chk("drop_ovf", 32'(overflow), 32'(OVF_EXP));
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    chk("ovf_clr", 32'(overflow), 0);
    rx_data = 8'h77; rx_done = 1'b1; ovf_clr = 1'b1;
    @(posedge clk); #1;
    rx_done = 1'b0; ovf_clr = 1'b0;
    chk("ovf_set_wins", 32'(overflow), 32'(OVF_EXP));
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    chk("ovf_clr2", 32'(overflow), 0);
    chk("drop2_count", 32'(count), 8);

    // Push and pop together while full: nothing is dropped.
    rx_data = 8'hAA; rx_done = 1'b1; rd = 1'b1;
    exp_q.push_back(8'hAA);
    @(posedge clk); #1;
    rd = 1'b0; rx_done = 1'b0;
    chk("pp_count", 32'(count), 8);
    chk("pp_full", 32'(full), 1);
    chk("pp_ovf", 32'(overflow), 0);
    drain("drain2");

    // Run the pointers around the ring several times.
    for (int i = 0; i < 20; i++) begin
      push(8'(8'h30 + i), 1'b1);
      rd = 1'b1;
      @(posedge clk); #1;
      rd = 1'b0;
    end
    chk("wrap_count", 32'(count), 0);
    push(8'hC1, 1'b1);
    push(8'hC2, 1'b1);
    push(8'hC3, 1'b1);
    chk("wrap3_count", 32'(count), 3);
    chk("wrap3_dout", 32'(dout), 32'hC1);

    // Reset mid-operation with rx_done high: queue is discarded, and there is no push on release.
    rx_data = 8'hEE; rx_done = 1'b1; rst = 1'b1;
    exp_q.delete();
    #1;
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_valid", 32'(valid), 0);
    chk("mid_rst_dout", 32'(dout), 0);
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("rel_no_push", 32'(count), 0);
    rx_done = 1'b0;
    @(posedge clk); #1;
    rx_data = 8'hE1; rx_done = 1'b1;
    exp_q.push_back(8'hE1);
    @(posedge clk); #1;
    rx_done = 1'b0;
    chk("rel_push_count", 32'(count), 1);
    chk("rel_push_dout", 32'(dout), 32'hE1);
    drain("drain3");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
